sramlike_arbiter: RTL and testbench
===================================

// Module: sramlike_arbiter
// PURPOSE
//  2:1 arbiter sharing one SRAM-like slave port between the inst-fetch and
//  data-access SRAM-like masters (outputs of the i-side and d-side bridges).
//  Owns sequencing: grant, address phase, data phase, response routing.
//  One outstanding transaction at a time. Sits between the bridges and the
//  AXI/memory interface.
// PARAMETERS
//  ADDR_W  32  address width of all ports
//  DATA_W  32  read/write data width of all ports
// PORTS
//  clk                          in   1       clock
//  rst                          in   1       synchronous reset, active-high
//  inst_req / data_req          in   1       master request
//  inst_wr / data_wr            in   1       master write flag (inst_wr normally 0)
//  inst_size / data_size        in   2       0=byte,1=half,2=word
//  inst_addr / data_addr        in   ADDR_W  master address
//  inst_wdata / data_wdata      in   DATA_W  master write data
//  inst_rdata / data_rdata      out  DATA_W  read data (both = rdata)
//  inst_addr_ok / data_addr_ok  out  1       address handshake to master
//  inst_data_ok / data_data_ok  out  1       data handshake to master
//  req / wr                     out  1       shared-port request / write
//  size                         out  2       shared-port size
//  addr / wdata                 out  ADDR_W / DATA_W  shared payload
//  rdata                        in   DATA_W  slave read data
//  addr_ok / data_ok            in   1       slave handshakes
// BEHAVIOUR
//  Reset: state=IDLE, owner=INST, last_grant=INST; req=0; all *_addr_ok and
//   *_data_ok = 0. Reset mid-transaction abandons it; later slave
//   data_ok is ignored because state is IDLE.
//  States: IDLE, ADDR, DATA (registered). owner: 1-bit register, INST/DATA.
//  IDLE: if inst_req|data_req, pick the winner, latch owner, go ADDR.
//   The grant costs 1 cycle: req stays 0 in that IDLE cycle.
//  ADDR: req=1; wr/size/addr/wdata = owner's inputs (combinational mux).
//   owner_addr_ok=addr_ok. On addr_ok go DATA, otherwise hold.
//   Masters hold their payload stable until addr_ok.
//  DATA: req=0. On data_ok: owner_data_ok=1 in the same cycle and go IDLE.
//   If the other master's req is high in that cycle, re-arbitrate: latch
//   owner and go directly to ADDR (no IDLE bubble). The owner's own req
//   is low here.
//  Non-owner addr_ok/data_ok are always 0. data_ok outside DATA is ignored.
//   addr_ok outside ADDR is ignored. rdata is not registered.
//  Simultaneous addr_ok and data_ok in ADDR: take addr_ok only (go DATA).
//  Default priority on conflict: data wins (fixed).
//  last_grant updates on every grant.
// CONFIGURATION
//  ARB_RR_EN defined: round-robin. On conflict the master that is not
//   last_grant wins. A lone requester always wins.
//  ARB_RR_EN undefined: fixed data>inst priority. last_grant is still kept
//   but not used.
// TESTING
//  1 inst_req only, inst_addr=0xBFC00000; slave addr_ok at +2, data_ok at
//    +4 with rdata=0x3C1DBFC0 -> addr=0xBFC00000, one inst_addr_ok pulse,
//    one inst_data_ok pulse with inst_rdata=0x3C1DBFC0; data_* ok stays 0.
//  2 inst_req and data_req (data_addr=0x80001000) together -> data served
//    first; cycle after data_data_ok, addr=inst_addr and req=1 (no bubble).
//  3 With ARB_RR_EN, both reqs held high for 3 transactions -> grant order
//    data, inst, data.
//  4 addr_ok held low 5 cycles -> req stays 1; addr/wr/wdata stay stable;
//    state stays ADDR; no *_ok pulse.
//  5 data write: data_wr=1, size=2, wdata=0xDEADBEEF -> wr=1 and
//    wdata=0xDEADBEEF on shared port; data_data_ok pulses; inst unaffected.
//  6 rst asserted in DATA, then slave data_ok next cycle -> req=0, no
//    *_data_ok pulse, state IDLE.

Source files
------------

// File: rtl/sramlike_arbiter.sv
// 2:1 arbiter sharing one SRAM-like slave port between the inst and data masters.
// Define ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority.
module sramlike_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,

    output logic              req,
    output logic              wr,
    output logic [1:0]        size,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              addr_ok,
    input  logic              data_ok
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    state_t state_q, state_n;
    owner_t owner_q, owner_n;
    owner_t last_grant_q, last_grant_n;
    owner_t winner;
    owner_t other;
    logic   other_req;
    logic   sel_data;
    logic   in_addr;
    logic   in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_INST;
            last_grant_q <= OWN_INST;
        end else begin
            state_q      <= state_n;
            owner_q      <= owner_n;
            last_grant_q <= last_grant_n;
        end
    end

    always_comb begin
`ifdef ARB_RR_EN
        if (inst_req && data_req)
            winner = (last_grant_q == OWN_INST) ? OWN_DATA : OWN_INST;
        else
            winner = data_req ? OWN_DATA : OWN_INST;
`else
        winner = data_req ? OWN_DATA : OWN_INST;
`endif
    end

    // On completion the next grant can only go to the master that is not the owner.
    always_comb begin
        other     = (owner_q == OWN_INST) ? OWN_DATA : OWN_INST;
        other_req = (owner_q == OWN_INST) ? data_req : inst_req;
    end

    always_comb begin
        state_n      = state_q;
        owner_n      = owner_q;
        last_grant_n = last_grant_q;
        case (state_q)
            S_IDLE: begin
                if (inst_req || data_req) begin
                    owner_n      = winner;
                    last_grant_n = winner;
                    state_n      = S_ADDR;
                end
            end
            S_ADDR: begin
                if (addr_ok)
                    state_n = S_DATA;
            end
            S_DATA: begin
                if (data_ok) begin
                    state_n = S_IDLE;
                    if (other_req) begin
                        owner_n      = other;
                        last_grant_n = other;
                        state_n      = S_ADDR;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        sel_data = (owner_q == OWN_DATA);
        in_addr  = !rst && (state_q == S_ADDR);
        in_data  = !rst && (state_q == S_DATA);

        req   = in_addr;
        wr    = sel_data ? data_wr    : inst_wr;
        size  = sel_data ? data_size  : inst_size;
        addr  = sel_data ? data_addr  : inst_addr;
        wdata = sel_data ? data_wdata : inst_wdata;

        inst_addr_ok = in_addr && !sel_data && addr_ok;
        data_addr_ok = in_addr &&  sel_data && addr_ok;
        inst_data_ok = in_data && !sel_data && data_ok;
        data_data_ok = in_data &&  sel_data && data_ok;

        inst_rdata = rdata;
        data_rdata = rdata;
    end

endmodule

// File: tb/tb_sramlike_arbiter.sv
// Table-driven directed bench for sramlike_arbiter, plus a held-request grant-order sequence.
module tb_sramlike_arbiter;

    localparam logic [31:0] IADDR  = 32'hBFC00000;
    localparam logic [31:0] DADDR  = 32'h80001000;
    localparam logic [31:0] IWDATA = 32'h11111111;
    localparam logic [31:0] DWDATA = 32'hDEADBEEF;
`ifdef ARB_RR_EN
    localparam logic RR = 1'b1;
`else
    localparam logic RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0, inst_wr = 1'b0;
    logic [1:0]  inst_size = 2'd2;
    logic [31:0] inst_addr = IADDR, inst_wdata = IWDATA;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [31:0] data_addr = DADDR, data_wdata = DWDATA;
    logic [31:0] data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata = '0;
    logic        addr_ok = 1'b0, data_ok = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sramlike_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok)
    );

    typedef struct {
        logic        rst, ireq, dreq, dwr;
        logic [1:0]  dsize;
        logic        aok, dok;
        logic [31:0] rdata;
        logic        req, own, iaok, idok, daok, ddok;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic ir, input logic dr, input logic dw,
                       input logic [1:0] ds, input logic ao, input logic dk,
                       input logic [31:0] rd, input logic e_req, input logic e_own,
                       input logic e_iaok, input logic e_idok, input logic e_daok,
                       input logic e_ddok);
        vec_t v;
        v.rst = r; v.ireq = ir; v.dreq = dr; v.dwr = dw; v.dsize = ds;
        v.aok = ao; v.dok = dk; v.rdata = rd;
        v.req = e_req; v.own = e_own; v.iaok = e_iaok; v.idok = e_idok;
        v.daok = e_daok; v.ddok = e_ddok;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        logic [135:0] act, exp;
        logic [66:0]  pay_exp;
        logic         grant_order[3];
        int           ngrant;

        // rst ireq dreq dwr dsize aok dok rdata | req own iaok idok daok ddok
        add(1,0,0,0,0,0,0,32'h0,        0,0,0,0,0,0);  // reset state
        add(1,0,0,0,0,1,1,32'h0,        0,0,0,0,0,0);  // slave oks during reset
        add(0,1,0,0,0,0,0,32'h0,        0,0,0,0,0,0);  // inst grant bubble
        add(0,1,0,0,0,0,0,32'h0,        1,0,0,0,0,0);
        add(0,1,0,0,0,1,0,32'h0,        1,0,1,0,0,0);  // addr_ok at +2
        add(0,0,0,0,0,0,0,32'h0,        0,0,0,0,0,0);
        add(0,0,0,0,0,0,1,32'h3C1DBFC0, 0,0,0,1,0,0);  // data_ok at +4
        add(0,0,0,0,0,1,1,32'h55AA55AA, 0,0,0,0,0,0);  // stray oks in IDLE
        add(0,1,1,0,0,0,0,32'h0,        0,0,0,0,0,0);  // conflict
        add(0,1,1,0,0,0,0,32'h0,        1,1,0,0,0,0);  // data wins
        add(0,1,1,0,0,1,1,32'h0,        1,1,0,0,1,0);  // addr_ok beats data_ok
        add(0,1,0,0,0,0,0,32'h0,        0,0,0,0,0,0);
        add(0,1,0,0,0,0,1,32'h12345678, 0,0,0,0,0,1);  // re-arbitrate to inst
        add(0,1,0,0,0,1,0,32'h0,        1,0,1,0,0,0);  // no bubble
        add(0,0,0,0,0,0,1,32'hA5A5A5A5, 0,0,0,1,0,0);
        add(0,0,1,1,2,0,0,32'h0,        0,0,0,0,0,0);  // data write
        for (int i = 0; i < 5; i++)
            add(0,0,1,1,2,0,0,32'h0,    1,1,0,0,0,0);  // addr_ok stall
        add(0,0,1,1,2,1,0,32'h0,        1,1,0,0,1,0);
        add(0,0,0,0,0,0,1,32'hCAFEF00D, 0,0,0,0,0,1);
        add(0,1,0,0,0,0,0,32'h0,        0,0,0,0,0,0);  // reset mid-transaction
        add(0,1,0,0,0,1,0,32'h0,        1,0,1,0,0,0);
        add(1,0,0,0,0,0,0,32'h0,        0,0,0,0,0,0);
        add(0,0,0,0,0,0,1,32'h0BADF00D, 0,0,0,0,0,0);
        add(0,0,0,0,0,0,0,32'h0,        0,0,0,0,0,0);
        add(0,0,1,0,2,0,0,32'h0,        0,0,0,0,0,0);  // leave last_grant = data
        add(0,0,1,0,2,1,0,32'h0,        1,1,0,0,1,0);
        add(0,0,0,0,0,0,1,32'h0,        0,0,0,0,0,1);
        add(0,1,1,0,1,0,0,32'h0,        0,0,0,0,0,0);  // conflict after data grant
        add(0,1,1,0,1,1,0,32'h0,        1,!RR,RR,0,!RR,0);
        add(0,0,0,0,0,0,1,32'h0,        0,0,0,RR,0,!RR);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst = vecs[i].rst; inst_req = vecs[i].ireq; data_req = vecs[i].dreq;
            data_wr = vecs[i].dwr; data_size = vecs[i].dsize;
            addr_ok = vecs[i].aok; data_ok = vecs[i].dok; rdata = vecs[i].rdata;
            #4;
            pay_exp = vecs[i].own ? {vecs[i].dwr, vecs[i].dsize, DADDR, DWDATA}
                                  : {1'b0, 2'd2, IADDR, IWDATA};
            act = {req, req ? {wr, size, addr, wdata} : 67'd0,
                   inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
                   inst_rdata, data_rdata};
            exp = {vecs[i].req, vecs[i].req ? pay_exp : 67'd0,
                   vecs[i].iaok, vecs[i].idok, vecs[i].daok, vecs[i].ddok,
                   vecs[i].rdata, vecs[i].rdata};
            check($sformatf("vec%0d", i), act, exp);
        end

        // Both masters held high with an always-ready slave: grants alternate data, inst, data.
        @(posedge clk); #1;
        rst = 1'b1; inst_req = 1'b0; data_req = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
        data_wr = 1'b0; data_size = 2'd2; rdata = '0;
        @(posedge clk); #1;
        rst = 1'b0; inst_req = 1'b1; data_req = 1'b1; addr_ok = 1'b1; data_ok = 1'b1;
        ngrant = 0;
        for (int c = 0; c < 20 && ngrant < 3; c++) begin
            #4;
            if (inst_addr_ok || data_addr_ok) begin
                grant_order[ngrant] = data_addr_ok;
                ngrant++;
            end
            @(posedge clk); #1;
        end
        check("grant_count", 136'(ngrant), 136'd3);
        if (ngrant == 3) begin
            check("grant0_data", 136'(grant_order[0]), 136'd1);
            check("grant1_inst", 136'(grant_order[1]), 136'd0);
            check("grant2_data", 136'(grant_order[2]), 136'd1);
        end
        inst_req = 1'b0; data_req = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
